// File: rtl/i2c_target.sv
// I2C target: matches a 7-bit address, accepts or returns DATA_WIDTH-bit words.
// Bus is oversampled on clk; scl is never stretched.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  inout  wire                   sda,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  n_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  busy,
  output logic                  rw
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BW-1:0] LAST = BW'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE,
    WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            scl_sync_q, sda_sync_q;
  logic                  scl_prev_q, sda_prev_q;
  logic [2:0]            bit_q, bit_d;
  logic [BW-1:0]         byte_q, byte_d;
  logic [6:0]            addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] odata_q, odata_d;
  logic                  oe_q, oe_d;
  logic                  busy_q, busy_d;
  logic                  rw_q, rw_d;
  logic                  ovalid_q, ovalid_d;
  logic                  ndata_q, ndata_d;

  logic scl_s, sda_s, scl_rise, scl_fall, start, stop;

  assign scl_s    = scl_sync_q[1];
  assign sda_s    = sda_sync_q[1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign start    = scl_s & sda_prev_q & ~sda_s;
  assign stop     = scl_s & ~sda_prev_q & sda_s;

  assign sda     = oe_q ? 1'b0 : 1'bz;
  assign n_data  = ndata_q;
  assign o_valid = ovalid_q;
  assign o_data  = odata_q;
  assign busy    = busy_q;
  assign rw      = rw_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      bit_q      <= '0;
      byte_q     <= '0;
      addr_q     <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      odata_q    <= '0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      ovalid_q   <= 1'b0;
      ndata_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      addr_q     <= addr_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      odata_q    <= odata_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      ovalid_q   <= ovalid_d;
      ndata_q    <= ndata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    addr_d   = addr_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    odata_d  = odata_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    rw_d     = rw_q;
    ovalid_d = 1'b0;
    ndata_d  = 1'b0;
    if (start) begin
      state_d = ADDR;
      bit_d   = '0;
      byte_d  = '0;
      busy_d  = 1'b0;
      oe_d    = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      bit_d   = '0;
      byte_d  = '0;
      busy_d  = 1'b0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          if (bit_q == 3'd7) begin
            bit_d = '0;
            if (addr_q == DEV_ADDR) begin
              rw_d    = sda_s;
              state_d = ADDR_ACK;
            end else begin
              state_d = WAIT_STOP;
            end
          end else begin
            addr_d = {addr_q[5:0], sda_s};
            bit_d  = bit_q + 3'd1;
          end
        end
        // first fall starts the ACK, second fall ends it
        ADDR_ACK: if (scl_fall) begin
          if (!oe_q) begin
            oe_d   = 1'b1;
            busy_d = 1'b1;
          end else if (rw_q) begin
            tx_d    = i_data;
            ndata_d = 1'b1;
            oe_d    = ~i_data[DATA_WIDTH-1];
            state_d = RD_BYTE;
          end else begin
            oe_d    = 1'b0;
            state_d = WR_BYTE;
          end
        end
        WR_BYTE: if (scl_rise) begin
          rx_d  = {rx_q[DATA_WIDTH-2:0], sda_s};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = WR_ACK;
            if (byte_q == LAST) begin
              odata_d  = {rx_q[DATA_WIDTH-2:0], sda_s};
              ovalid_d = 1'b1;
              byte_d   = '0;
            end else begin
              byte_d = byte_q + BW'(1);
            end
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!oe_q) begin
            oe_d = 1'b1;
          end else begin
            oe_d    = 1'b0;
            state_d = WR_BYTE;
          end
        end
        RD_BYTE: if (scl_fall) begin
          tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            oe_d    = 1'b0;
            state_d = RD_ACK;
          end else begin
            bit_d = bit_q + 3'd1;
            oe_d  = ~tx_q[DATA_WIDTH-2];
          end
        end
        // bit_q flags a received ACK until the fall that drives the next bit
        RD_ACK: begin
          if (scl_rise && bit_q == 3'd0) begin
            if (!sda_s) begin
              bit_d = 3'd1;
              if (byte_q == LAST) begin
                tx_d    = i_data;
                ndata_d = 1'b1;
                byte_d  = '0;
              end else begin
                byte_d = byte_q + BW'(1);
              end
            end else begin
              state_d = WAIT_STOP;
            end
          end else if (scl_fall && bit_q == 3'd1) begin
            bit_d   = '0;
            oe_d    = ~tx_q[DATA_WIDTH-1];
            state_d = RD_BYTE;
          end
        end
        WAIT_STOP: oe_d = 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged controller with scoreboard queues
// for written words and read bytes.
module tb_i2c_target;

  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        m_low = 1'b0;
  logic [31:0] i_data = '0;
  wire         sda;
  logic        n_data, o_valid, busy, rw;
  logic [31:0] o_data;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_target #(.DEV_ADDR(7'h50), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .i_data(i_data), .n_data(n_data), .o_data(o_data),
    .o_valid(o_valid), .busy(busy), .rw(rw)
  );

  int n_chk = 0;
  int n_err = 0;
  int ov_cnt = 0;
  int nd_cnt = 0;
  logic [31:0] exp_w[$];
  logic [7:0]  exp_b[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (o_valid) begin
      ov_cnt++;
      if (exp_w.size() == 0) check("ov_unexpected_q", exp_w.size(), 1);
      else check("o_data", o_data, exp_w.pop_front());
    end
    if (n_data) begin
      nd_cnt++;
      check("excl_nd_ov", {31'd0, o_valid}, 0);
    end
  end

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_x(input logic b, output logic r);
    m_low = !b; wq();
    scl = 1'b1; wq();
    r = sda; wq();
    scl = 1'b0; wq();
  endtask

  task automatic start_c();
    m_low = 1'b0; wq();
    scl = 1'b1; wq();
    m_low = 1'b1; wq();
    scl = 1'b0; wq();
  endtask

  task automatic stop_c();
    m_low = 1'b1; wq();
    scl = 1'b1; wq();
    m_low = 1'b0; wq(); wq();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(b[i], r);
    bit_x(1'b1, ack);
  endtask

  task automatic rd_byte(output logic [7:0] b, input logic ack_it);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, r);
      b[i] = r;
    end
    bit_x(!ack_it, r);
  endtask

  task automatic wr_word(input logic [31:0] w);
    logic a;
    for (int k = 0; k < 4; k++) begin
      wr_byte(w[31-8*k -: 8], a);
      check("wr_data_ack", {31'd0, a}, 0);
    end
  endtask

  initial begin
    logic a;
    logic [7:0] b;
    int ov0, nd0;

    repeat (5) @(negedge clk);
    check("rst_sda", {31'd0, sda}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_rw", {31'd0, rw}, 0);
    check("rst_odata", o_data, 0);
    check("rst_pulses", {30'd0, n_data, o_valid}, 0);
    rst = 1'b0;
    wq();

    // plain write
    ov0 = ov_cnt;
    start_c();
    wr_byte(8'hA0, a);
    check("wr_addr_ack", {31'd0, a}, 0);
    check("wr_busy", {31'd0, busy}, 1);
    check("wr_rw", {31'd0, rw}, 0);
    exp_w.push_back(32'h12345678);
    wr_word(32'h12345678);
    check("wr_busy_last", {31'd0, busy}, 1);
    stop_c();
    check("wr_busy_end", {31'd0, busy}, 0);
    check("wr_ov_cnt", ov_cnt - ov0, 1);
    check("wr_odata", o_data, 32'h12345678);

    // read with NACK on last byte
    i_data = 32'hDEADBEEF;
    nd0 = nd_cnt;
    ov0 = ov_cnt;
    start_c();
    wr_byte(8'hA1, a);
    check("rd_addr_ack", {31'd0, a}, 0);
    check("rd_rw", {31'd0, rw}, 1);
    check("rd_busy", {31'd0, busy}, 1);
    exp_b.push_back(8'hDE);
    exp_b.push_back(8'hAD);
    exp_b.push_back(8'hBE);
    exp_b.push_back(8'hEF);
    for (int k = 0; k < 4; k++) begin
      rd_byte(b, k < 3);
      check("rd_byte", {24'd0, b}, {24'd0, exp_b.pop_front()});
    end
    check("rd_nack_release", {31'd0, sda}, 1);
    stop_c();
    check("rd_nd_cnt", nd_cnt - nd0, 1);
    check("rd_ov_cnt", ov_cnt - ov0, 0);
    check("rd_busy_end", {31'd0, busy}, 0);

    // address mismatch, then a valid write
    nd0 = nd_cnt;
    ov0 = ov_cnt;
    start_c();
    wr_byte(8'hA2, a);
    check("mm_nack", {31'd0, a}, 1);
    check("mm_busy", {31'd0, busy}, 0);
    stop_c();
    check("mm_pulses", (ov_cnt - ov0) + (nd_cnt - nd0), 0);
    start_c();
    wr_byte(8'hA0, a);
    check("mm_wr_ack", {31'd0, a}, 0);
    exp_w.push_back(32'hCAFEF00D);
    wr_word(32'hCAFEF00D);
    stop_c();
    check("mm_ov_cnt", ov_cnt - ov0, 1);

    // partial write, repeated START into a read
    ov0 = ov_cnt;
    i_data = 32'hA5C30F96;
    start_c();
    wr_byte(8'hA0, a);
    wr_byte(8'h12, a);
    wr_byte(8'h34, a);
    check("pw_ack", {31'd0, a}, 0);
    start_c();
    wr_byte(8'hA1, a);
    check("pw_rd_ack", {31'd0, a}, 0);
    check("pw_rw", {31'd0, rw}, 1);
    exp_b.push_back(8'hA5);
    rd_byte(b, 1'b0);
    check("pw_rd_byte", {24'd0, b}, {24'd0, exp_b.pop_front()});
    stop_c();
    check("pw_ov_cnt", ov_cnt - ov0, 0);
    check("pw_odata", o_data, 32'hCAFEF00D);

    // two words in one transaction
    ov0 = ov_cnt;
    start_c();
    wr_byte(8'hA0, a);
    exp_w.push_back(32'h01020304);
    exp_w.push_back(32'h05060708);
    wr_word(32'h01020304);
    wr_word(32'h05060708);
    stop_c();
    check("mw_ov_cnt", ov_cnt - ov0, 2);
    check("mw_q_empty", exp_w.size(), 0);

    // reset while the target drives sda low
    i_data = 32'h00FF00FF;
    start_c();
    wr_byte(8'hA1, a);
    check("rr_ack", {31'd0, a}, 0);
    check("rr_drive_low", {31'd0, sda}, 0);
    rst = 1'b1;
    #1;
    check("rr_sda_rel", {31'd0, sda}, 1);
    check("rr_busy", {31'd0, busy}, 0);
    check("rr_rw", {31'd0, rw}, 0);
    check("rr_odata", o_data, 0);
    check("rr_pulses", {30'd0, n_data, o_valid}, 0);
    repeat (3) @(negedge clk);
    scl = 1'b1;
    m_low = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wq();
    ov0 = ov_cnt;
    start_c();
    wr_byte(8'hA0, a);
    check("rr_wr_ack", {31'd0, a}, 0);
    exp_w.push_back(32'h0BADF00D);
    wr_word(32'h0BADF00D);
    stop_c();
    check("rr_ov_cnt", ov_cnt - ov0, 1);
    check("rr_odata_new", o_data, 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (responder) answering transactions from I2C_Controller on the shared open-drain scl/sda bus.
- Decodes START/STOP, matches a 7-bit device address, and accepts or returns DATA_WIDTH-bit words MSB-first as bytes.
- Uses a word-level valid/next handshake on the system side; oversamples the bus with the system clock and never stretches scl.

Parameters:
- DEV_ADDR, 7'h50, 7-bit target address matched against the first byte after START.
- DATA_WIDTH, 32, word width; must be a multiple of 8 (NBYTES = DATA_WIDTH/8).

Ports:
- clk  input  1  system clock; must be at least 16x the scl frequency.
- rst  input  1  asynchronous active-high reset.
- scl  input  1  I2C clock; the block samples it and never drives it.
- sda  inout  1  I2C data; the block drives only 1'b0 or 1'bz.
- i_data  input  DATA_WIDTH  read word to return to the controller.
- n_data  output  1  one-cycle pulse; i_data was latched, present the next word.
- o_data  output  DATA_WIDTH  last word written by the controller.
- o_valid  output  1  one-cycle pulse; o_data is updated.
- busy  output  1  high from an address-matched ACK until STOP or repeated START.
- rw  output  1  R/W bit of the current matched transaction (1 = read).

Behaviour:
- Reset values: sda released (z), n_data=0, o_valid=0, o_data=0, busy=0, rw=0, state=IDLE, all counters 0.
- Async rst: release sda within the same cycle, regardless of state.
- Synchronisation: scl and sda pass through 2-flop synchronisers. Edges are detected on the synced values.
- START = synced sda falls while synced scl high.
- STOP = synced sda rises while synced scl high.
- Sampling: data bits are sampled on the synced scl rising edge. The block changes sda only on the synced scl falling edge.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
- START in any state, including repeated START: go to ADDR, clear bit/byte counters, busy=0, release sda.
- STOP in any state: go to IDLE, busy=0, release sda. Discard any partial write word; o_valid does not pulse.
- ADDR: shift in 8 bits (7 address bits MSB-first, then R/W).
  - On the 8th rising edge with an address match: latch rw; go to ADDR_ACK.
  - On a mismatch: go to WAIT_STOP with sda released (NACK).
- ADDR_ACK: drive sda low from the falling edge after bit 8 to the falling edge after bit 9. Set busy=1.
  - rw=0: go to WR_BYTE.
  - rw=1: latch i_data into the tx shift register, pulse n_data, go to RD_BYTE. The first data bit is driven on the falling edge that ends the ACK.
- WR_BYTE: shift 8 bits into the rx register MSB-first, then go to WR_ACK. Drive an ACK for every byte.
  - After byte NBYTES: copy the rx register to o_data and pulse o_valid for one cycle, coincident with the 8th rising edge of the last byte. Byte counter wraps to 0.
  - Further bytes start a new word.
- RD_BYTE: drive the tx MSB for each bit. A 1 is expressed by releasing sda, a 0 by driving it low. After 8 bits, release sda on the falling edge and go to RD_ACK.
- RD_ACK: sample sda on the 9th rising edge.
  - ACK (0), mid-word: go to RD_BYTE with the next byte.
  - ACK (0), after byte NBYTES: latch i_data, pulse n_data, byte counter wraps to 0.
  - NACK (1): go to WAIT_STOP with sda released.
- WAIT_STOP: sda released. Leaves only on STOP (to IDLE) or START (to ADDR).
- Simultaneous edges: a START/STOP detected in the same cycle as an scl edge takes priority; no bit is shifted.
- n_data and o_valid never assert in the same cycle. Each is exactly one clk wide.

Test Plan:
- Write: START, 0xA0 (addr 0x50, W), bytes 12 34 56 78, STOP.
  - Target ACKs all 5 bytes.
  - o_data=32'h12345678, one o_valid pulse after byte 4.
  - busy high from ADDR_ACK to STOP.
- Read: i_data=32'hDEADBEEF; START, 0xA1; controller ACKs 3 bytes, NACKs the 4th; STOP.
  - Bus carries DE AD BE EF.
  - n_data pulses once at ADDR_ACK and not again.
  - sda released after the NACK.
- Address mismatch: START, 0xA2, STOP.
  - No ACK (sda high on the 9th clock); busy stays 0; no o_valid or n_data.
  - A following valid write still succeeds.
- Partial write then repeated START: write 12 34, repeated START, 0xA1 read.
  - o_valid never pulses; o_data unchanged.
  - Read proceeds with rw=1.
- Multi-word write: 8 data bytes 01..08.
  - Two o_valid pulses: o_data=32'h01020304, then 32'h05060708.
- Reset mid-read: assert rst while the target drives sda low.
  - sda is z in the same cycle; all outputs return to reset values.
  - The next START is decoded normally.
